// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies its lock output as
// stable, then releases the downstream DDR reset. If lock does not arrive in
// time, the PLL reset is retried a bounded number of times before a sticky
// failure is flagged. All outputs are registered.
module pll_lock_supervisor #(
   parameter int RESET_CYCLES = 16,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int LOCK_STABLE  = 1024,
   parameter int MAX_RETRY    = 7,
   parameter int CNT_W        = 16
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       pll_lock_i,
   output logic       pll_reset_o,
   output logic       sys_rst_o,
   output logic       ready_o,
   output logic       lock_lost_o,
   output logic [3:0] retry_cnt_o,
   output logic       fail_o
);

   typedef enum logic [2:0] {
      ST_RST_PLL   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   // Terminal counts are compared against the value held before the edge,
   // so a phase lasting N cycles ends when the counter reads N-1.
   localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

   state_t           state_reg;
   logic [CNT_W-1:0] phase_cnt_reg;
   logic [CNT_W-1:0] tmo_cnt_reg;
   logic             lock_meta_reg;
   logic             lock_s_reg;

   logic             timeout_hit;
   logic             retry_left;

   // The timeout counter can step one past LOCK_TIMEOUT-1 when lock arrives
   // on the very last waiting cycle, so expiry is a >= test, not ==.
   assign timeout_hit = (tmo_cnt_reg >= TMO_LAST);
   assign retry_left  = (retry_cnt_o < RETRY_MAX);

   // Two-flop synchronizer bringing the asynchronous PLL lock into clkin.
   always_ff @(posedge clkin) begin
      if (reset) begin
         lock_meta_reg <= 1'b0;
         lock_s_reg    <= 1'b0;
      end else begin
         lock_meta_reg <= pll_lock_i;
         lock_s_reg    <= lock_meta_reg;
      end
   end

   // Supervisor FSM with its counters and all registered outputs.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_reg     <= ST_RST_PLL;
         phase_cnt_reg <= '0;
         tmo_cnt_reg   <= '0;
         pll_reset_o   <= 1'b1;
         sys_rst_o     <= 1'b1;
         ready_o       <= 1'b0;
         lock_lost_o   <= 1'b0;
         retry_cnt_o   <= 4'd0;
         fail_o        <= 1'b0;
      end else begin
         lock_lost_o <= 1'b0;
         case (state_reg)
            // Hold the PLL in reset for RESET_CYCLES; lock is ignored here.
            ST_RST_PLL: begin
               pll_reset_o <= 1'b1;
               sys_rst_o   <= 1'b1;
               ready_o     <= 1'b0;
               if (phase_cnt_reg == RESET_LAST) begin
                  state_reg     <= ST_WAIT_LOCK;
                  phase_cnt_reg <= '0;
                  tmo_cnt_reg   <= '0;
                  pll_reset_o   <= 1'b0;
               end else begin
                  phase_cnt_reg <= phase_cnt_reg + CNT_ONE;
               end
            end

            // Waiting for lock; the timeout window opened at reset release.
            ST_WAIT_LOCK: begin
               if (timeout_hit && !lock_s_reg) begin
                  if (retry_left) begin
                     retry_cnt_o   <= retry_cnt_o + 4'd1;
                     state_reg     <= ST_RST_PLL;
                     phase_cnt_reg <= '0;
                     tmo_cnt_reg   <= '0;
                     pll_reset_o   <= 1'b1;
                  end else begin
                     state_reg   <= ST_FAIL;
                     pll_reset_o <= 1'b1;
                     fail_o      <= 1'b1;
                  end
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + CNT_ONE;
                  if (lock_s_reg) begin
                     state_reg     <= ST_STABLE;
                     phase_cnt_reg <= '0;
                  end
               end
            end

            // Lock must stay high LOCK_STABLE cycles. The timeout window keeps
            // running across dropouts so a flapping lock still expires, and
            // expiry wins over stable completion on the same cycle.
            ST_STABLE: begin
               if (timeout_hit) begin
                  if (retry_left) begin
                     retry_cnt_o   <= retry_cnt_o + 4'd1;
                     state_reg     <= ST_RST_PLL;
                     phase_cnt_reg <= '0;
                     tmo_cnt_reg   <= '0;
                     pll_reset_o   <= 1'b1;
                  end else begin
                     state_reg   <= ST_FAIL;
                     pll_reset_o <= 1'b1;
                     fail_o      <= 1'b1;
                  end
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + CNT_ONE;
                  if (!lock_s_reg) begin
                     state_reg <= ST_WAIT_LOCK;
                  end else if (phase_cnt_reg == STABLE_LAST) begin
                     state_reg     <= ST_RUN;
                     phase_cnt_reg <= '0;
                     tmo_cnt_reg   <= '0;
                     sys_rst_o     <= 1'b0;
                     ready_o       <= 1'b1;
                     retry_cnt_o   <= 4'd0;
                  end else begin
                     phase_cnt_reg <= phase_cnt_reg + CNT_ONE;
                  end
               end
            end

            // In service; any loss of lock re-runs the whole bring-up.
            ST_RUN: begin
               retry_cnt_o <= 4'd0;
               if (!lock_s_reg) begin
                  state_reg     <= ST_RST_PLL;
                  phase_cnt_reg <= '0;
                  tmo_cnt_reg   <= '0;
                  pll_reset_o   <= 1'b1;
                  sys_rst_o     <= 1'b1;
                  ready_o       <= 1'b0;
                  lock_lost_o   <= 1'b1;
               end
            end

            // Terminal: PLL and downstream held in reset until block reset.
            ST_FAIL: begin
               pll_reset_o <= 1'b1;
               sys_rst_o   <= 1'b1;
               ready_o     <= 1'b0;
               fail_o      <= 1'b1;
            end

            // Unreachable encodings recover through a fresh PLL reset.
            default: begin
               state_reg     <= ST_RST_PLL;
               phase_cnt_reg <= '0;
               tmo_cnt_reg   <= '0;
               pll_reset_o   <= 1'b1;
               sys_rst_o     <= 1'b1;
               ready_o       <= 1'b0;
            end
         endcase
      end
   end

endmodule
